// File: rtl/uart_tx_arbiter.sv
// Round-robin sharer of one uart_tx among four byte requesters, with a
// per-requester lock held until the byte flagged last has been sent.
module uart_tx_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_req,
  input  logic [31:0] i_data_in,
  input  logic [3:0]  i_last,
  output logic [3:0]  o_ack,
  output logic [3:0]  o_grant,
  output logic        o_busy,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic [2:0]  o_dbg_state,
  output logic [1:0]  o_dbg_ptr
);

  // Handshake: i_req[i] is a level request held until o_ack[i] pulses; the byte
  // and last flag are taken on the edge that raises o_ack, and the requester
  // presents its next byte (or drops i_req) during the ack cycle.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [1:0]  r_owner;
  logic        r_last;
  logic [3:0]  r_ack;
  logic [3:0]  r_grant;
  logic        r_busy;
  logic        r_tx_start;
  logic [7:0]  r_tx_data;

  logic        w_found;
  logic [1:0]  w_win;
  logic [1:0]  w_idx;
  logic [7:0]  w_win_byte;
  logic [7:0]  w_own_byte;

  // Scan from the farthest slot back to ptr+1 so the nearest requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int i = 4; i >= 1; i--) begin
      w_idx = r_ptr + 2'(i);
      if (i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_byte = i_data_in[{w_win, 3'b000} +: 8];
  assign w_own_byte = i_data_in[{r_owner, 3'b000} +: 8];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'd3;
      r_owner    <= 2'd0;
      r_last     <= 1'b0;
      r_ack      <= 4'd0;
      r_grant    <= 4'd0;
      r_busy     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'd0;
    end else begin
      r_ack      <= 4'd0;
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_tx_ready && w_found) begin
            r_tx_data  <= w_win_byte;
            r_last     <= i_last[w_win];
            r_owner    <= w_win;
            r_grant    <= 4'b0001 << w_win;
            r_ack      <= 4'b0001 << w_win;
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!i_tx_ready) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_tx_ready) begin
            if (r_last) begin
              r_ptr   <= r_owner;
              r_grant <= 4'd0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Locked: only the owner may continue, and it may stall indefinitely.
          if (i_req[r_owner]) begin
            r_tx_data  <= w_own_byte;
            r_last     <= i_last[r_owner];
            r_ack      <= 4'b0001 << r_owner;
            r_tx_start <= 1'b1;
            r_state    <= S_START;
          end
        end
        default: begin
          r_grant <= 4'd0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ack       = r_ack;
  assign o_grant     = r_grant;
  assign o_busy      = r_busy;
  assign o_tx_start  = r_tx_start;
  assign o_tx_data   = r_tx_data;
  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` serial transmitter among four byte requesters. It sits between client logic and the `uart_tx` instance, drives its `start`/`data` inputs, and tracks its `ready` output to know when a frame has finished. A requester can lock the transmitter for a multi-byte message by holding `last` low until its final byte.

## Interface
- No parameters. The requester count is fixed at 4, and the baud rate belongs to the `uart_tx` instance.
- `clk`  in  1  system clock, shared with `uart_tx`.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  per-requester byte request; level, held until acknowledged.
- `data_in`  in  32  requester i's byte on bits `[8i+7:8i]`.
- `last`  in  4  per-requester end-of-message flag, sampled together with the byte.
- `ack`  out  4  one-hot, one-cycle pulse: byte of requester i accepted.
- `grant`  out  4  one-hot owner of the transmitter; 0 when free.
- `busy`  out  1  high whenever state is not IDLE.
- `tx_start`  out  1  to `uart_tx.start`.
- `tx_data`  out  8  to `uart_tx.data`.
- `tx_ready`  in  1  from `uart_tx.ready`; combinational from its state, high in its IDLE.

## Operation
- All outputs are registered.
- Reset values:
  - state = IDLE, `ptr` = 3, `grant` = 0, `ack` = 0.
  - `tx_start` = 0, `tx_data` = 0, `busy` = 0, `last_r` = 0.
- Round-robin search order is ptr+1, ptr+2, ptr+3, ptr (mod 4); the first set `req` bit wins.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, HOLD.
- **IDLE**: if `tx_ready`=1 and `req`≠0, select winner g and do all of the following in one edge:
  - `tx_data` <= byte g; `last_r` <= `last[g]`.
  - `grant` <= onehot(g); `ack[g]` <= 1.
  - Go to START.
  - If `tx_ready`=0, stay in IDLE.
- **START**: `tx_start`=1 for exactly this one cycle. Go to WAIT_BUSY.
- **WAIT_BUSY**: wait for `tx_ready`=0 (the transmitter entered its START state), then go to WAIT_DONE.
- **WAIT_DONE**: wait for `tx_ready`=1 (frame complete).
  - If `last_r`=1: `ptr` <= g, `grant` <= 0, go to IDLE.
  - Otherwise go to HOLD.
- **HOLD**: owner g keeps the lock; other requests are ignored.
  - When `req[g]`=1: latch byte g and `last[g]`, pulse `ack[g]`, go to START.
  - HOLD has no timeout; clients must finish their messages.
- Requester contract:
  - Byte and `last` are sampled on the edge that raises `ack`.
  - The requester presents the next byte (or drops `req`) in the cycle `ack` is high.
  - A `req` still high while `ack` is high is a fresh request.
- Losers are never dropped; their `req` stays pending and they win in round-robin order.
- `tx_data` holds its value from the latch until the next latch.

## Timing
- IDLE with `req`/`tx_ready` sampled at edge k:
  - `ack`, `grant`, `tx_data` and `tx_start` are valid after edge k+1 (state START).
  - `uart_tx` samples `start` at edge k+2.
  - `tx_ready` falls after k+3.
- Back-to-back locked bytes: HOLD → START costs 1 cycle after `tx_ready` rises, plus 1 cycle in WAIT_DONE. The gap between frames is ≤3 clk plus the transmitter's own idle cycle.
- `req` going high in the same cycle as another requester's release: the arbiter releases to IDLE first, then arbitrates on the next edge using the updated `ptr`.
- `rst` mid-frame forces all outputs to their reset values on the next edge.
  - Any in-flight `uart_tx` frame is not aborted.
  - After reset, IDLE waits for `tx_ready`=1 before granting.
- `ack` is never high for two consecutive cycles.
- `tx_start` is never high outside START.

## Test plan
- Single request: `req`=0001, `data_in[7:0]`=0x55, `last`=0001 → one `ack[0]` pulse, exactly one `tx_start` cycle with `tx_data`=0x55, `grant`=0001 until `tx_ready` returns, then `grant`=0, `ptr`=0.
- Contention after reset: `req`=1111, all `last`=1, held high → frames sent in order 0,1,2,3,0,…; each `ack` is one cycle.
- Locked message: requester 2 sends 0x41,0x42,0x43 with `last` high only on 0x43, while `req`=1011 pending → three consecutive frames from 2 with no interleaving, then requester 3 wins.
- HOLD stall: requester 1 with `last`=0 drops `req` for 50 cycles → `grant` stays 0010, no `tx_start`; on `req[1]` high, the next byte goes out within 2 cycles.
- `tx_ready` low at request (transmitter busy from reset) → no `ack` until `tx_ready`=1, then normal grant.
- Reset asserted in WAIT_DONE → next cycle all outputs are 0, `ptr`=3, and the first subsequent `req`=0101 grants requester 0.
